// File: rtl/dequant_pkg.sv
// Shared constants, FSM state type and the per-lane saturating multiply for the dequantizer.
// DEQUANT_SYM_CLAMP_EN maps INT4 code -8 to -7 before multiplication.
package dequant_pkg;

    localparam int N_LANE   = 16;
    localparam int N_ROW    = 64;
    localparam int ROW_AW   = 6;
    localparam int SF_W     = 18;
    localparam int Q_W      = 4;
    localparam int OUT_W    = 18;
    localparam int P_W      = Q_W + SF_W + 1;
    localparam int ROW_W    = N_LANE * OUT_W;
    localparam int SF_BUS_W = N_LANE * SF_W;
    localparam int Q_BUS_W  = N_LANE * Q_W;

    localparam logic signed [P_W-1:0] P_MAX = 23'sd131071;
    localparam logic signed [P_W-1:0] P_MIN = -23'sd131072;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    function automatic logic signed [OUT_W-1:0] sat_mul(input logic signed [Q_W-1:0] q,
                                                        input logic [SF_W-1:0] sf);
        logic signed [Q_W-1:0] qc;
        logic signed [P_W-1:0] p;
        qc = q;
`ifdef DEQUANT_SYM_CLAMP_EN
        if (q == 4'sb1000) qc = 4'sb1001;
`endif
        p = qc * $signed({1'b0, sf});
        if (p > P_MAX) return {1'b0, {(OUT_W-1){1'b1}}};
        else if (p < P_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
        else return p[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/dequant_fifo.sv
// Two-entry synchronous FIFO holding dequantized rows tagged with their last-row flag.
// The caller guarantees no push when full and no pop when empty.
module dequant_fifo #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occupancy,
    output logic [W-1:0] head_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign occupancy = count;
    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/dequantize.sv
// Reads 64 INT4 rows from the quantized-data RAM, rescales them by the latched per-lane
// scale factors and streams INT18 rows out over valid/ready. Option: DEQUANT_SYM_CLAMP_EN.
module dequantize
    import dequant_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sf_valid,
    input  logic [SF_BUS_W-1:0] i_sf_data,
    output logic                o_ram_re,
    output logic [ROW_AW-1:0]   o_ram_addr,
    input  logic [Q_BUS_W-1:0]  i_ram_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [ROW_W-1:0]    o_data,
    output logic                o_last,
    output logic                o_busy,
    output logic                o_overrun
);

    state_t              state_q;
    state_t              state_d;
    logic [SF_BUS_W-1:0] sf_q;
    logic [ROW_AW-1:0]   rd_cnt;
    logic [ROW_AW-1:0]   last_addr;
    logic                rd_pend;
    logic                rd_pend_last;
    logic [ROW_W-1:0]    row_dq;
    logic [1:0]          fifo_occ;
    logic [ROW_W:0]      fifo_head;
    logic [1:0]          occ_after_pop;
    logic                pop;
    logic                credit_ok;
    logic                rd_is_last;

    assign o_valid       = (fifo_occ != 2'd0);
    assign pop           = o_valid && i_ready;
    assign o_data        = fifo_head[ROW_W-1:0];
    assign o_last        = o_valid && fifo_head[ROW_W];
    assign rd_is_last    = (rd_cnt == ROW_AW'(N_ROW - 1));
    // A row leaving this cycle frees its slot in time for a read issued now.
    assign occ_after_pop = fifo_occ - {1'b0, pop};
    assign credit_ok     = ({1'b0, occ_after_pop} + {2'b0, rd_pend}) < 3'd2;
    assign o_ram_addr    = o_ram_re ? rd_cnt : last_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_sf_valid) state_d = READ;
            READ:    if (o_ram_re && rd_is_last) state_d = DRAIN;
            DRAIN:   if (pop && fifo_head[ROW_W]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ram_re = (state_q == READ) && credit_ok;
        o_busy   = (state_q != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sf_q         <= '0;
            rd_cnt       <= '0;
            last_addr    <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (state_q == IDLE && i_sf_valid) begin
                sf_q   <= i_sf_data;
                rd_cnt <= '0;
            end
            if (o_ram_re) begin
                rd_cnt    <= rd_cnt + 1'b1;
                last_addr <= rd_cnt;
            end
            rd_pend      <= o_ram_re;
            rd_pend_last <= o_ram_re && rd_is_last;
            o_overrun    <= i_sf_valid && (state_q != IDLE);
        end
    end

    always_comb begin
        row_dq = '0;
        for (int k = 0; k < N_LANE; k++) begin
            row_dq[k*OUT_W +: OUT_W] = sat_mul(i_ram_data[k*Q_W +: Q_W], sf_q[k*SF_W +: SF_W]);
        end
    end

    dequant_fifo #(.W(ROW_W + 1)) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (rd_pend),
        .push_data ({rd_pend_last, row_dq}),
        .pop       (pop),
        .occupancy (fifo_occ),
        .head_data (fifo_head)
    );

endmodule

// File: tb/tb_dequantize.sv
// Randomized scoreboard bench for dequantize: the driver queues expected rows from an
// arithmetic model, and a negedge monitor checks rows, addresses, busy, overrun and stalls.
module tb_dequantize;
    import dequant_pkg::*;

    localparam int CW = 320;

    typedef struct {
        logic [ROW_W-1:0] data;
        logic             last;
    } row_t;

    logic                i_clk = 1'b0;
    logic                i_rst_n = 1'b0;
    logic                i_sf_valid = 1'b0;
    logic [SF_BUS_W-1:0] i_sf_data = '0;
    logic                o_ram_re;
    logic [ROW_AW-1:0]   o_ram_addr;
    logic [Q_BUS_W-1:0]  i_ram_data = '0;
    logic                o_valid;
    logic                i_ready = 1'b0;
    logic [ROW_W-1:0]    o_data;
    logic                o_last;
    logic                o_busy;
    logic                o_overrun;

    int   ram [N_ROW][N_LANE];
    int   sf_m [N_LANE];
    row_t exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int accept_cyc = -1;
    int ovr_due = -1;
    int done_cyc = -1;
    int first_pop_cyc = -1;
    int issued = 0;
    int popped = 0;
    int exp_addr = 0;

    logic              pend_re = 1'b0;
    logic [ROW_AW-1:0] pend_addr = '0;
    bit                prev_stall = 1'b0;
    logic [ROW_W:0]    prev_out = '0;

    dequantize dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_sf_valid (i_sf_valid),
        .i_sf_data  (i_sf_data),
        .o_ram_re   (o_ram_re),
        .o_ram_addr (o_ram_addr),
        .i_ram_data (i_ram_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [CW-1:0] actual, input logic [CW-1:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [ROW_W-1:0] model_row(input int r);
        logic [ROW_W-1:0]   row;
        int                 q;
        int                 p;
        logic signed [31:0] pv;
        row = '0;
        for (int k = 0; k < N_LANE; k++) begin
            q = ram[r][k];
`ifdef DEQUANT_SYM_CLAMP_EN
            if (q == -8) q = -7;
`endif
            p = q * sf_m[k];
            if (p > 131071) p = 131071;
            else if (p < -131072) p = -131072;
            pv = p;
            row[k*OUT_W +: OUT_W] = pv[OUT_W-1:0];
        end
        return row;
    endfunction

    function automatic logic [Q_BUS_W-1:0] pack_row(input int r);
        logic [Q_BUS_W-1:0] bus;
        logic signed [31:0] qv;
        bus = '0;
        for (int k = 0; k < N_LANE; k++) begin
            qv = ram[r][k];
            bus[k*Q_W +: Q_W] = qv[Q_W-1:0];
        end
        return bus;
    endfunction

    function automatic logic [SF_BUS_W-1:0] pack_sf();
        logic [SF_BUS_W-1:0] bus;
        logic [31:0]         v;
        bus = '0;
        for (int k = 0; k < N_LANE; k++) begin
            v = sf_m[k];
            bus[k*SF_W +: SF_W] = v[SF_W-1:0];
        end
        return bus;
    endfunction

    // One clock: drive inputs for this cycle, then answer the RAM read one cycle later.
    task automatic applyStimulus(input bit ready, input bit sfv);
        i_ready    = ready;
        i_sf_valid = sfv;
        @(negedge i_clk);
        pend_re   = o_ram_re;
        pend_addr = o_ram_addr;
        @(posedge i_clk);
        #1;
        if (pend_re) i_ram_data = pack_row(int'(pend_addr));
        i_sf_valid = 1'b0;
    endtask

    task automatic pulseSf(input bit expect_accept, input bit ready);
        row_t e;
        i_sf_data = pack_sf();
        if (expect_accept) begin
            accept_cyc = cyc;
            for (int r = 0; r < N_ROW; r++) begin
                e.data = model_row(r);
                e.last = (r == N_ROW - 1);
                exp_q.push_back(e);
            end
        end else begin
            ovr_due = cyc + 1;
        end
        applyStimulus(ready, 1'b1);
    endtask

    task automatic runBlock(input bit random_ready);
        bit done;
        bit rdy;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            rdy = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(rdy, 1'b0);
            done = (done_cyc >= accept_cyc);
        end
        checkOutput("block_done", CW'(done), CW'(1));
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic setPattern(input int sf_val);
        for (int k = 0; k < N_LANE; k++) sf_m[k] = sf_val;
        for (int r = 0; r < N_ROW; r++)
            for (int k = 0; k < N_LANE; k++)
                ram[r][k] = ((r + k) % 16 > 7) ? ((r + k) % 16) - 16 : (r + k) % 16;
    endtask

    task automatic setRandom();
        for (int k = 0; k < N_LANE; k++) sf_m[k] = int'($urandom_range(0, 262143));
        for (int r = 0; r < N_ROW; r++)
            for (int k = 0; k < N_LANE; k++)
                ram[r][k] = int'($urandom_range(0, 15)) - 8;
    endtask

    // Scoreboard monitor: everything the DUT presents is checked away from the rising edge.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (cyc == accept_cyc) begin
                exp_addr = 0;
                issued   = 0;
                popped   = 0;
            end
            checkOutput("o_busy", CW'(o_busy), CW'((cyc > accept_cyc) && (done_cyc < accept_cyc)));
            if (o_overrun || cyc == ovr_due)
                checkOutput("o_overrun", CW'(o_overrun), CW'(cyc == ovr_due));
            if (prev_stall) begin
                checkOutput("stall_valid", CW'(o_valid), CW'(1));
                checkOutput("stall_hold", CW'({o_last, o_data}), CW'(prev_out));
            end
            if (o_valid && i_ready) begin
                checkOutput("row_expected", CW'(exp_q.size() != 0), CW'(1));
                if (exp_q.size() != 0) begin
                    checkOutput("row_data", CW'({o_last, o_data}),
                                CW'({exp_q[0].last, exp_q[0].data}));
                    popped++;
                    if (popped == 1) first_pop_cyc = cyc;
                    if (exp_q[0].last) done_cyc = cyc;
                    void'(exp_q.pop_front());
                end
            end
            if (o_ram_re) begin
                checkOutput("ram_addr", CW'(o_ram_addr), CW'(exp_addr));
                exp_addr++;
                issued++;
                checkOutput("outstanding_le2", CW'((issued - popped) <= 2), CW'(1));
            end
            prev_stall = o_valid && !i_ready;
            prev_out   = {o_last, o_data};
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit wait_ok;

        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("reset_outputs",
                    CW'({o_ram_re, o_ram_addr, o_valid, o_last, o_busy, o_overrun, o_data}), '0);
        i_rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);

        // Reset while rows are being read, then restart from address 0.
        setPattern(1000);
        pulseSf(1'b1, 1'b1);
        wait_ok = 1'b0;
        for (int i = 0; i < 50 && !wait_ok; i++) begin
            applyStimulus(1'b1, 1'b0);
            wait_ok = (issued >= 11);
        end
        checkOutput("reached_row10", CW'(wait_ok), CW'(1));
        i_rst_n    = 1'b0;
        accept_cyc = -10;
        #1;
        checkOutput("midread_reset_outputs",
                    CW'({o_ram_re, o_ram_addr, o_valid, o_last, o_busy, o_overrun, o_data}), '0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        i_rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0);

        // sf = 1000 everywhere, ramp pattern, consumer always ready.
        pulseSf(1'b1, 1'b1);
        runBlock(1'b0);
        checkOutput("first_row_latency", CW'(first_pop_cyc - accept_cyc), CW'(3));
        checkOutput("last_row_cycle", CW'(done_cyc - accept_cyc), CW'(66));

        // Saturation corner: lane 0 sf = 18432 with codes -8 and 7.
        setRandom();
        sf_m[0]   = 18432;
        ram[0][0] = -8;
        ram[1][0] = 7;
        pulseSf(1'b1, 1'b1);
        runBlock(1'b1);

        // Random data with a 50% ready consumer.
        for (int b = 0; b < 2; b++) begin
            setRandom();
            pulseSf(1'b1, 1'b0);
            runBlock(1'b1);
        end

        // A second sf pulse during row 20's readout must be ignored and flagged.
        setRandom();
        pulseSf(1'b1, 1'b1);
        for (int i = 0; i < 22; i++) applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < N_LANE; k++) sf_m[k] = int'($urandom_range(0, 262143));
        pulseSf(1'b0, 1'b1);
        runBlock(1'b0);

        // Back-to-back blocks: second sf at cycle 67 after the first is accepted cleanly.
        setRandom();
        pulseSf(1'b1, 1'b1);
        for (int i = 0; i < 66; i++) applyStimulus(1'b1, 1'b0);
        setRandom();
        pulseSf(1'b1, 1'b1);
        runBlock(1'b0);
        checkOutput("b2b_first_row_latency", CW'(first_pop_cyc - accept_cyc), CW'(3));

        checkOutput("queue_drained", CW'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
